// File: rtl/note_seq_recorder_if.sv
// Bus between the keyboard tracker/control panel and the note sequence recorder.
// The master drives keys, strobes and mode controls.
// The slave (the recorder) returns the played note and its status.
interface note_seq_recorder_if #(
  parameter int NOTES  = 9,
  parameter int TRACKS = 2,
  parameter int TW     = 1,
  parameter int SW_W   = 4
) ();
  logic [NOTES-1:0]  key;
  logic              rec_stb;
  logic              tick;
  logic [1:0]        mode;
  logic [TW-1:0]     track_sel;
  logic [TRACKS-1:0] play_mask;
  logic              loop;
  logic [NOTES-1:0]  note_out;
  logic              playing;
  logic              rec_full;
  logic [SW_W-1:0]   step_idx;

  modport master (
    output key, rec_stb, tick, mode, track_sel, play_mask, loop,
    input  note_out, playing, rec_full, step_idx
  );

  modport slave (
    input  key, rec_stb, tick, mode, track_sel, play_mask, loop,
    output note_out, playing, rec_full, step_idx
  );
endinterface

// File: rtl/note_seq_recorder.sv
// Multi-track one-hot note recorder and player.
// Records one-hot notes and rests per track on a capture strobe.
// Plays a masked mix of tracks on a tempo tick, with optional looping.
// Everything runs in the single clk domain.
module note_seq_recorder #(
  parameter int NOTES  = 9,
  parameter int DEPTH  = 10,
  parameter int TRACKS = 2,
  parameter int TW     = 1,
  parameter int SW_W   = 4
) (
  input logic clk,
  input logic reset,
  note_seq_recorder_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LIVE = 2'b01;
  localparam logic [1:0] ST_REC  = 2'b10;
  localparam logic [1:0] ST_PLAY = 2'b11;

  localparam logic [SW_W-1:0]  DEPTH_V  = SW_W'(DEPTH);
  localparam logic [SW_W-1:0]  STEP_ONE = SW_W'(1);
  localparam logic [NOTES-1:0] KEY_ONE  = NOTES'(1);

  logic [1:0]       state;
  logic [1:0]       target;
  logic             changing;
  logic             play_done;
  logic [NOTES-1:0] note_q;
  logic             playing_q;
  logic [SW_W-1:0]  step_q;
  logic [SW_W-1:0]  len [TRACKS];
  logic [NOTES-1:0] mem [TRACKS][DEPTH];

  logic             key_onehot;
  logic             key_ok;
  logic             rec_we;
  logic [SW_W-1:0]  maxlen;
  logic             end_of_seq;
  logic             wrap;
  logic [SW_W-1:0]  play_idx;
  logic [NOTES-1:0] mix;

  // Map mode to the wanted state; a finished play run stays idle until mode leaves play.
  always_comb begin
    target = ST_IDLE;
    case (bus.mode)
      2'b00:   target = ST_LIVE;
      2'b01:   target = ST_REC;
      2'b10:   target = play_done ? ST_IDLE : ST_PLAY;
      default: target = ST_IDLE;
    endcase
  end

  assign changing   = (target != state);
  assign key_onehot = (bus.key != '0) && ((bus.key & (bus.key - KEY_ONE)) == '0);
  assign key_ok     = key_onehot || (bus.key == '0);
  assign rec_we     = (state == ST_REC) && !changing && bus.rec_stb && key_ok &&
                      (len[bus.track_sel] < DEPTH_V);

  // Work out the longest masked track and the mixed note for the step a tick would play.
  always_comb begin
    maxlen = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (bus.play_mask[t] && (len[t] > maxlen)) maxlen = len[t];
    end
    end_of_seq = (step_q >= maxlen);
    wrap       = end_of_seq && bus.loop && (maxlen != '0);
    play_idx   = wrap ? '0 : step_q;
    mix        = '0;
    for (int t = 0; t < TRACKS; t++) begin
      if (bus.play_mask[t] && (play_idx < len[t])) mix = mix | mem[t][play_idx];
    end
  end

  // Note storage; contents past a track's length are never read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (rec_we) mem[bus.track_sel][len[bus.track_sel]] <= bus.key;
  end

  // Mode-driven state machine: a mode change takes priority over strobe and tick that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      play_done <= 1'b0;
      note_q    <= '0;
      playing_q <= 1'b0;
      step_q    <= '0;
      for (int t = 0; t < TRACKS; t++) len[t] <= '0;
    end else begin
      state <= target;
      if (bus.mode != 2'b10) play_done <= 1'b0;
      if (bus.mode == 2'b11) begin
        step_q <= '0;
        for (int t = 0; t < TRACKS; t++) len[t] <= '0;
      end
      case (target)
        ST_LIVE: begin
          playing_q <= 1'b0;
          note_q    <= key_onehot ? bus.key : '0;
        end
        ST_REC: begin
          playing_q <= 1'b0;
          if (changing) begin
            len[bus.track_sel] <= '0;
            note_q             <= KEY_ONE << bus.track_sel;
          end else if (rec_we) begin
            len[bus.track_sel] <= len[bus.track_sel] + STEP_ONE;
          end
        end
        ST_PLAY: begin
          if (changing) begin
            step_q    <= '0;
            playing_q <= 1'b1;
            note_q    <= '0;
          end else if (bus.tick || ((step_q == '0) && (maxlen == '0))) begin
            if (end_of_seq && !wrap) begin
              note_q    <= '0;
              playing_q <= 1'b0;
              state     <= ST_IDLE;
              play_done <= 1'b1;
            end else begin
              note_q <= mix;
              step_q <= wrap ? STEP_ONE : step_q + STEP_ONE;
            end
          end
        end
        default: begin
          note_q    <= '0;
          playing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.note_out = note_q;
  assign bus.playing  = playing_q;
  assign bus.step_idx = step_q;
  assign bus.rec_full = (len[bus.track_sel] == DEPTH_V);
endmodule

// File: tb/tb_note_seq_recorder.sv
// Randomized self-checking bench for note_seq_recorder.
// A behavioural model keeps each track as a plain note list with a length.
// Playback expectations are derived from those lists.
module tb_note_seq_recorder;
  localparam int NOTES  = 9;
  localparam int DEPTH  = 10;
  localparam int TRACKS = 2;
  localparam int TW     = 1;
  localparam int SW_W   = 4;

  localparam logic [NOTES-1:0] KQ = 9'b100000000;
  localparam logic [NOTES-1:0] KW = 9'b010000000;
  localparam logic [NOTES-1:0] KE = 9'b001000000;
  localparam logic [NOTES-1:0] KO = 9'b000000001;

  logic clk = 1'b0;
  logic reset;

  // Free-running system clock.
  always #5 clk = ~clk;

  note_seq_recorder_if #(.NOTES(NOTES), .TRACKS(TRACKS), .TW(TW), .SW_W(SW_W)) bus ();

  note_seq_recorder #(.NOTES(NOTES), .DEPTH(DEPTH), .TRACKS(TRACKS), .TW(TW), .SW_W(SW_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [NOTES-1:0] m_notes [TRACKS][DEPTH];
  int               m_len   [TRACKS];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [NOTES-1:0] k,
                               input logic stb, input logic tk);
    bus.mode    = m;
    bus.key     = k;
    bus.rec_stb = stb;
    bus.tick    = tk;
    @(posedge clk);
    #1;
    bus.rec_stb = 1'b0;
    bus.tick    = 1'b0;
  endtask

  function automatic logic [NOTES-1:0] randKey();
    int r;
    int b1;
    int b2;
    logic [NOTES-1:0] k;
    r  = $urandom_range(0, 3);
    b1 = $urandom_range(0, NOTES - 1);
    b2 = (b1 + 1 + $urandom_range(0, NOTES - 2)) % NOTES;
    k  = '0;
    if (r == 1 || r == 2) k[b1] = 1'b1;
    if (r == 3) begin
      k[b1] = 1'b1;
      k[b2] = 1'b1;
    end
    return k;
  endfunction

  function automatic int modelMaxLen(input logic [TRACKS-1:0] mask);
    int ml = 0;
    for (int t = 0; t < TRACKS; t++)
      if (mask[t] && m_len[t] > ml) ml = m_len[t];
    return ml;
  endfunction

  function automatic logic [NOTES-1:0] modelMix(input int p, input logic [TRACKS-1:0] mask);
    logic [NOTES-1:0] acc = '0;
    for (int t = 0; t < TRACKS; t++)
      if (mask[t] && p < m_len[t]) acc = acc | m_notes[t][p];
    return acc;
  endfunction

  task automatic modelClear();
    for (int t = 0; t < TRACKS; t++) m_len[t] = 0;
  endtask

  task automatic enterRec(input int trk);
    logic [NOTES-1:0] exp_ind;
    applyStimulus(2'b00, '0, 1'b0, 1'b0);
    bus.track_sel = trk[TW-1:0];
    applyStimulus(2'b01, randKey(), 1'($urandom_range(0, 1)), 1'b0);
    m_len[trk] = 0;
    exp_ind = '0;
    exp_ind[trk] = 1'b1;
    checkOutput("rec_entry_indicator", bus.note_out, exp_ind);
    checkOutput("rec_entry_full", bus.rec_full, 0);
  endtask

  task automatic recordKey(input logic [NOTES-1:0] k);
    int trk;
    trk = bus.track_sel;
    if ($urandom_range(0, 3) == 0) begin
      applyStimulus(2'b01, k, 1'b0, 1'b0);
      checkOutput("rec_gap_full", bus.rec_full, (m_len[trk] == DEPTH));
    end
    applyStimulus(2'b01, k, 1'b1, 1'b0);
    if ($countones(k) <= 1 && m_len[trk] < DEPTH) begin
      m_notes[trk][m_len[trk]] = k;
      m_len[trk]++;
    end
    checkOutput("rec_full", bus.rec_full, (m_len[trk] == DEPTH));
  endtask

  task automatic playRun(input logic [TRACKS-1:0] mask, input logic lp, input int nticks,
                         input bit vary);
    int p = 0;
    int k = 0;
    int ml;
    bit active = 1'b1;
    bus.play_mask = mask;
    bus.loop      = lp;
    applyStimulus(2'b10, '0, 1'b0, 1'($urandom_range(0, 1)));
    checkOutput("play_entry_playing", bus.playing, 1);
    checkOutput("play_entry_step", bus.step_idx, 0);
    if (modelMaxLen(bus.play_mask) == 0) begin
      applyStimulus(2'b10, '0, 1'b0, 1'b0);
      checkOutput("play_empty_playing", bus.playing, 0);
      checkOutput("play_empty_note", bus.note_out, 0);
      active = 1'b0;
    end
    while (active && k < nticks) begin
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(2'b10, '0, 1'b0, 1'b0);
        checkOutput("play_hold_step", bus.step_idx, p);
        checkOutput("play_hold_playing", bus.playing, 1);
      end
      if (vary && k > 0 && $urandom_range(0, 3) == 0) bus.play_mask = TRACKS'($urandom_range(0, 3));
      applyStimulus(2'b10, '0, 1'b0, 1'b1);
      ml = modelMaxLen(bus.play_mask);
      if (p >= ml) begin
        if (bus.loop && ml > 0) begin
          p = 0;
        end else begin
          checkOutput("play_end_note", bus.note_out, 0);
          checkOutput("play_end_playing", bus.playing, 0);
          active = 1'b0;
        end
      end
      if (active) begin
        checkOutput("play_note", bus.note_out, modelMix(p, bus.play_mask));
        p++;
        checkOutput("play_step", bus.step_idx, p);
        checkOutput("play_playing", bus.playing, 1);
      end
      k++;
    end
    if (!active) begin
      applyStimulus(2'b10, '0, 1'b0, 1'b1);
      checkOutput("play_no_rearm_playing", bus.playing, 0);
      checkOutput("play_no_rearm_note", bus.note_out, 0);
    end
    applyStimulus(2'b00, '0, 1'b0, 1'b0);
    checkOutput("play_leave_playing", bus.playing, 0);
  endtask

  // Main stimulus sequence: directed scenarios followed by randomized record/play rounds.
  initial begin
    logic [NOTES-1:0] k;
    reset         = 1'b1;
    bus.mode      = 2'b11;
    bus.key       = '0;
    bus.rec_stb   = 1'b0;
    bus.tick      = 1'b0;
    bus.track_sel = '0;
    bus.play_mask = '0;
    bus.loop      = 1'b0;
    modelClear();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_note", bus.note_out, 0);
    checkOutput("reset_playing", bus.playing, 0);
    checkOutput("reset_step", bus.step_idx, 0);
    checkOutput("reset_full", bus.rec_full, 0);
    reset = 1'b0;
    applyStimulus(2'b11, '0, 1'b0, 1'b0);

    // Live pass-through
    applyStimulus(2'b00, 9'b000010000, 1'b0, 1'b0);
    checkOutput("live_onehot", bus.note_out, 9'b000010000);
    applyStimulus(2'b00, 9'b000011000, 1'b0, 1'b0);
    checkOutput("live_multihot", bus.note_out, 0);
    for (int i = 0; i < 16; i++) begin
      k = randKey();
      applyStimulus(2'b00, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("live_rand", bus.note_out, ($countones(k) == 1) ? k : '0);
    end

    // Fill track 0 past its depth, then play it back once
    enterRec(0);
    for (int i = 0; i < 11; i++) begin
      k = '0;
      k[i % NOTES] = 1'b1;
      recordKey(k);
    end
    checkOutput("full_len", m_len[0], DEPTH);
    playRun(2'b01, 1'b0, 12, 1'b0);

    // Rests and ignored multi-hot on track 1
    enterRec(1);
    recordKey(KQ);
    recordKey('0);
    recordKey(KQ | KW);
    recordKey(KE);
    checkOutput("rest_len", m_len[1], 3);
    playRun(2'b10, 1'b0, 4, 1'b0);

    // Mixed looping playback and non-looping end
    enterRec(0);
    recordKey(KQ);
    recordKey(KW);
    enterRec(1);
    recordKey(KO);
    playRun(2'b11, 1'b1, 5, 1'b0);
    playRun(2'b01, 1'b0, 3, 1'b0);

    // Randomized record/play rounds, including track switches mid-record
    for (int r = 0; r < 10; r++) begin
      for (int t = 0; t < TRACKS; t++) begin
        if ($urandom_range(0, 1) == 1) begin
          enterRec(t);
          for (int i = $urandom_range(0, 12); i > 0; i--) begin
            if ($urandom_range(0, 7) == 0) bus.track_sel = ~bus.track_sel;
            recordKey(randKey());
          end
        end
      end
      playRun(TRACKS'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(1, 24), 1'b1);
    end

    // Asynchronous reset between ticks
    enterRec(0);
    recordKey(KQ);
    recordKey(KW);
    bus.play_mask = 2'b01;
    bus.loop      = 1'b1;
    applyStimulus(2'b10, '0, 1'b0, 1'b0);
    applyStimulus(2'b10, '0, 1'b0, 1'b1);
    checkOutput("prereset_note", bus.note_out, KQ);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_note", bus.note_out, 0);
    checkOutput("async_reset_playing", bus.playing, 0);
    checkOutput("async_reset_step", bus.step_idx, 0);
    bus.mode = 2'b11;
    @(posedge clk);
    #1;
    reset = 1'b0;
    modelClear();
    playRun(2'b11, 1'b1, 3, 1'b0);

    // Clear while playing, then play empty tracks
    enterRec(1);
    recordKey(KO);
    bus.play_mask = 2'b10;
    bus.loop      = 1'b1;
    applyStimulus(2'b10, '0, 1'b0, 1'b0);
    applyStimulus(2'b10, '0, 1'b0, 1'b1);
    checkOutput("preclear_note", bus.note_out, KO);
    applyStimulus(2'b11, '0, 1'b0, 1'b1);
    modelClear();
    checkOutput("clear_note", bus.note_out, 0);
    checkOutput("clear_playing", bus.playing, 0);
    checkOutput("clear_full", bus.rec_full, 0);
    playRun(2'b11, 1'b1, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_seq_recorder.md
Name: note_seq_recorder

Overview:
- Multi-track keyboard note recorder/player for the sampler datapath.
- Sits between the PS/2 keyboard tracker (one-hot note bus) and the LED/audio note consumer.
- Captures up to DEPTH one-hot notes per track on a capture strobe.
- Plays any subset of tracks simultaneously on a tempo tick, with optional looping.
- Generalises the fixed 9-note / 10-step / 2-track recorder.
- Adds over that recorder: rests, per-track lengths, mixed playback, loop, a full flag, and a clean clocked design (no gated-clock domains).

Parameters:
NOTES, 9, width of the one-hot note bus (keys q..o)
DEPTH, 10, maximum steps stored per track
TRACKS, 2, number of independent tracks
TW, 1, track-select width, equal to max(1, clog2(TRACKS))
SW_W, 4, step-index width, equal to clog2(DEPTH+1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
key  in  NOTES  current key state, one-hot expected
rec_stb  in  1  one-cycle capture pulse, already debounced and edge-detected upstream
tick  in  1  one-cycle playback step enable
mode  in  2  00 live, 01 record, 10 play, 11 clear-all
track_sel  in  TW  track written in record mode
play_mask  in  TRACKS  tracks mixed during play
loop  in  1  restart at end of sequence when 1
note_out  out  NOTES  registered note output
playing  out  1  high while in PLAY
rec_full  out  1  selected track holds DEPTH steps
step_idx  out  SW_W  current play step

Behaviour:
Reset values:
- All track lengths len[t]=0; state IDLE.
- note_out=0, playing=0, step_idx=0, rec_full=0.
- Storage contents are don't-care; only len governs validity.

States: IDLE, LIVE, REC, PLAY.
- The state follows mode each cycle: 00 to LIVE, 01 to REC, 10 to PLAY, 11 to IDLE.
- Exception: PLAY exits to IDLE at end of sequence; it re-arms only after mode leaves 10 and returns.

Mode priority:
- A mode change is evaluated before rec_stb or tick in the same cycle.
- The strobe is ignored on the cycle the state changes.

LIVE:
- note_out <= key if key is one-hot, else 0.
- One-cycle latency.

REC entry:
- len[track_sel] <= 0, which overwrites the track.
- note_out <= track_sel as a one-hot of the low bits; this is a visual indicator only.

REC, on rec_stb:
- key one-hot: mem[track_sel][len] <= key; len++.
- key == 0: store a rest (all zeros); len++.
- key multi-hot: ignored, len unchanged.
- len == DEPTH: write ignored; rec_full=1.
- track_sel changing while in REC does not clear the new track; writes append at that track's len.
- rec_full = (len[track_sel] == DEPTH), combinational on the registered len.

PLAY entry:
- step_idx=0, playing=1.
- Compute maxlen = max over masked tracks of len[t].
- maxlen == 0: go to IDLE next cycle, note_out=0, regardless of loop.

PLAY, on tick:
- note_out <= bitwise OR over t in play_mask of (step_idx < len[t] ? mem[t][step_idx] : 0).
- step_idx++.
- note_out updates the cycle after tick.
- Shorter tracks contribute silence past their end.

End of sequence:
- After the tick that outputs step maxlen-1, the next tick behaves as follows.
- loop=1: wrap step_idx to 0 and output step 0 on that same tick, with no gap.
- loop=0: note_out <= 0, playing <= 0, state IDLE.
- play_mask changes mid-play take effect at the next tick; maxlen is recomputed every tick.

Clear (mode 11):
- All len <= 0; note_out <= 0; playing <= 0.

Asynchronous reset mid-operation:
- Returns everything to reset values immediately.

IDLE:
- note_out holds 0.
- rec_stb and tick are ignored.

Widths:
- len and step_idx saturate at DEPTH and never wrap.
- Storage is a TRACKS x DEPTH x NOTES register array.

Test Plan:
- Live: mode=00, key=9'b000010000, then key=9'b000011000 -> note_out=9'b000010000 one cycle later, then 0.
- Record/full: mode=01, track 0, 11 rec_stb with one-hot keys -> len[0]=10 and rec_full=1 after the 10th; the 11th write is ignored and memory is unchanged.
- Rest/multi-hot: record q, key=0, key=q|w, e on track 1 -> len[1]=3; playback gives 9'b100000000, 0, 9'b001000000.
- Mix/loop: track0={q,w}, track1={o}, play_mask=2'b11, loop=1, 5 ticks -> note_out = q|o, w, q|o, w, q|o; step_idx wraps 1, 2, then back to 1.
- End/no-loop and empty: loop=0 with 2 steps -> third tick gives note_out=0 and playing=0; play_mask selecting only empty tracks -> playing drops after 1 cycle.
- Reset/clear mid-play: assert reset between ticks -> all outputs 0 asynchronously. mode=11 then play -> immediate exit, all lengths 0.
